// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : In-order queue of predicted branches; compares execute outcomes
//            against predictions, drives predictor updates and mispredict
//            redirect with full flush. Optional macro: BRU_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
  parameter int PCW      = 31,
  parameter int DEPTH    = 4,
  parameter int FALL_INC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [PCW-1:0]             push_pc_i,
  input  logic                       push_pred_taken_i,
  input  logic [PCW-1:0]             push_pred_target_i,
  input  logic                       resolve_valid_i,
  output logic                       resolve_ready_o,
  input  logic                       resolve_taken_i,
  input  logic [PCW-1:0]             resolve_target_i,
  output logic                       feedback_valid_o,
  output logic [PCW-1:0]             set_pc_o,
  output logic                       set_taken_o,
  output logic [PCW-1:0]             set_target_o,
  output logic                       mispredict_o,
  output logic [PCW-1:0]             redirect_pc_o,
`ifdef BRU_STATS_EN
  output logic [31:0]                stat_branches_o,
  output logic [31:0]                stat_mispredicts_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  C_FULL     = CW'(DEPTH);
  localparam logic [PCW-1:0] C_FALL_INC = PCW'(FALL_INC);

  logic [PCW-1:0] r_pc     [DEPTH];
  logic           r_ptaken [DEPTH];
  logic [PCW-1:0] r_ptgt   [DEPTH];

  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic           r_fb_valid;
  logic [PCW-1:0] r_set_pc;
  logic           r_set_taken;
  logic [PCW-1:0] r_set_target;
  logic           r_mispredict;
  logic [PCW-1:0] r_redirect_pc;

  logic           w_full;
  logic           w_empty;
  logic           w_res_acc;
  logic           w_mis;
  logic           w_pop;
  logic           w_push_acc;
  logic [PCW-1:0] w_head_pc;
  logic           w_head_ptaken;
  logic [PCW-1:0] w_head_ptgt;

  assign w_full        = (r_count == C_FULL);
  assign w_empty       = (r_count == '0);
  assign w_head_pc     = r_pc[r_rd_ptr];
  assign w_head_ptaken = r_ptaken[r_rd_ptr];
  assign w_head_ptgt   = r_ptgt[r_rd_ptr];

  assign push_ready_o    = !w_full && !r_mispredict;
  assign resolve_ready_o = !w_empty;

  assign w_res_acc = resolve_valid_i && resolve_ready_o;
  assign w_mis     = (w_head_ptaken != resolve_taken_i) ||
                     (w_head_ptaken && resolve_taken_i && (w_head_ptgt != resolve_target_i));
  assign w_pop     = w_res_acc && !w_mis;
  // A full queue still takes a push in the same cycle as a clean pop, so
  // occupancy holds at DEPTH; the freed head slot is the one written.
  assign w_push_acc = push_valid_i && !r_mispredict && (!w_full || w_pop) &&
                      !(w_res_acc && w_mis);

  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_pc[r_wr_ptr]     <= push_pc_i;
      r_ptaken[r_wr_ptr] <= push_pred_taken_i;
      r_ptgt[r_wr_ptr]   <= push_pred_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_fb_valid    <= 1'b0;
      r_set_pc      <= '0;
      r_set_taken   <= 1'b0;
      r_set_target  <= '0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_fb_valid   <= w_res_acc;
      r_mispredict <= w_res_acc && w_mis;
      if (w_res_acc) begin
        r_set_pc     <= w_head_pc;
        r_set_taken  <= resolve_taken_i;
        r_set_target <= resolve_taken_i ? resolve_target_i : w_head_ptgt;
        if (w_mis) begin
          r_redirect_pc <= resolve_taken_i ? resolve_target_i : (w_head_pc + C_FALL_INC);
        end
      end
      if (w_res_acc && w_mis) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push_acc, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else begin
      if (r_fb_valid)   r_stat_br  <= r_stat_br + 32'd1;
      if (r_mispredict) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_branches_o    = r_stat_br;
  assign stat_mispredicts_o = r_stat_mis;
`endif

  assign feedback_valid_o = r_fb_valid;
  assign set_pc_o         = r_set_pc;
  assign set_taken_o      = r_set_taken;
  assign set_target_o     = r_set_target;
  assign mispredict_o     = r_mispredict;
  assign redirect_pc_o    = r_redirect_pc;
  assign count_o          = r_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  localparam int PCW = 31;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           push_valid_i;
  logic           push_ready_o;
  logic [PCW-1:0] push_pc_i;
  logic           push_pred_taken_i;
  logic [PCW-1:0] push_pred_target_i;
  logic           resolve_valid_i;
  logic           resolve_ready_o;
  logic           resolve_taken_i;
  logic [PCW-1:0] resolve_target_i;
  logic           feedback_valid_o;
  logic [PCW-1:0] set_pc_o;
  logic           set_taken_o;
  logic [PCW-1:0] set_target_o;
  logic           mispredict_o;
  logic [PCW-1:0] redirect_pc_o;
  logic [2:0]     count_o;
`ifdef BRU_STATS_EN
  logic [31:0]    stat_branches_o;
  logic [31:0]    stat_mispredicts_o;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PCW(PCW), .DEPTH(4), .FALL_INC(1)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .push_valid_i       (push_valid_i),
    .push_ready_o       (push_ready_o),
    .push_pc_i          (push_pc_i),
    .push_pred_taken_i  (push_pred_taken_i),
    .push_pred_target_i (push_pred_target_i),
    .resolve_valid_i    (resolve_valid_i),
    .resolve_ready_o    (resolve_ready_o),
    .resolve_taken_i    (resolve_taken_i),
    .resolve_target_i   (resolve_target_i),
    .feedback_valid_o   (feedback_valid_o),
    .set_pc_o           (set_pc_o),
    .set_taken_o        (set_taken_o),
    .set_target_o       (set_target_o),
    .mispredict_o       (mispredict_o),
    .redirect_pc_o      (redirect_pc_o),
`ifdef BRU_STATS_EN
    .stat_branches_o    (stat_branches_o),
    .stat_mispredicts_o (stat_mispredicts_o),
`endif
    .count_o            (count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [PCW-1:0] pc,
                          input logic pt, input logic [PCW-1:0] tgt);
    push_valid_i       = v;
    push_pc_i          = pc;
    push_pred_taken_i  = pt;
    push_pred_target_i = tgt;
  endtask

  task automatic set_res(input logic v, input logic tk, input logic [PCW-1:0] tgt);
    resolve_valid_i  = v;
    resolve_taken_i  = tk;
    resolve_target_i = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    set_push(1'b0, '0, 1'b0, '0);
    set_res(1'b0, 1'b0, '0);
    step();
    step();
    check("rst_count",    32'(count_o), 0);
    check("rst_fb",       32'(feedback_valid_o), 0);
    check("rst_mis",      32'(mispredict_o), 0);
    check("rst_set_pc",   32'(set_pc_o), 0);
    check("rst_set_tk",   32'(set_taken_o), 0);
    check("rst_set_tgt",  32'(set_target_o), 0);
    check("rst_redirect", 32'(redirect_pc_o), 0);
    rst_n = 1'b1;
    step();
    check("post_rst_push_rdy", 32'(push_ready_o), 1);
    check("post_rst_res_rdy",  32'(resolve_ready_o), 0);

    // Correct taken prediction
    set_push(1'b1, 31'h10, 1'b1, 31'h40);
    step();
    set_push(1'b0, '0, 1'b0, '0);
    check("t1_count_push", 32'(count_o), 1);
    check("t1_res_rdy",    32'(resolve_ready_o), 1);
    set_res(1'b1, 1'b1, 31'h40);
    step();
    set_res(1'b0, 1'b0, '0);
    check("t1_fb",      32'(feedback_valid_o), 1);
    check("t1_set_pc",  32'(set_pc_o), 32'h10);
    check("t1_set_tk",  32'(set_taken_o), 1);
    check("t1_set_tgt", 32'(set_target_o), 32'h40);
    check("t1_mis",     32'(mispredict_o), 0);
    check("t1_count",   32'(count_o), 0);
    step();
    check("t1_fb_pulse", 32'(feedback_valid_o), 0);

    // Predicted taken, actually not taken
    set_push(1'b1, 31'h20, 1'b1, 31'h80);
    step();
    set_push(1'b0, '0, 1'b0, '0);
    set_res(1'b1, 1'b0, 31'h0);
    step();
    set_res(1'b0, 1'b0, '0);
    check("t2_set_tk",    32'(set_taken_o), 0);
    check("t2_set_tgt",   32'(set_target_o), 32'h80);
    check("t2_mis",       32'(mispredict_o), 1);
    check("t2_redirect",  32'(redirect_pc_o), 32'h21);
    check("t2_push_rdy",  32'(push_ready_o), 0);
    check("t2_count",     32'(count_o), 0);
    step();
    check("t2_mis_pulse", 32'(mispredict_o), 0);
    check("t2_push_rdy1", 32'(push_ready_o), 1);
    check("t2_redir_hold", 32'(redirect_pc_o), 32'h21);

    // Fill to full, overfill, then push+pop at full
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 31'(32'h100 + 4*i), 1'b0, 31'(32'h150 + 4*i));
      step();
    end
    check("t3_count_full", 32'(count_o), 4);
    check("t3_push_rdy",   32'(push_ready_o), 0);
    set_push(1'b1, 31'h200, 1'b0, 31'h250);
    step();
    check("t3_count_over", 32'(count_o), 4);
    set_push(1'b1, 31'h300, 1'b0, 31'h333);
    set_res(1'b1, 1'b0, '0);
    step();
    set_push(1'b0, '0, 1'b0, '0);
    check("t3_count_pp",  32'(count_o), 4);
    check("t3_pp_set_pc", 32'(set_pc_o), 32'h100);
    check("t3_pp_keep_tgt", 32'(set_target_o), 32'h150);
    check("t3_pp_mis",    32'(mispredict_o), 0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t3_drain_pc", 32'(set_pc_o), 32'h100 + 4*i);
      check("t3_drain_fb", 32'(feedback_valid_o), 1);
    end
    step();
    set_res(1'b0, 1'b0, '0);
    check("t3_drain_new", 32'(set_pc_o), 32'h300);
    check("t3_drain_mis", 32'(mispredict_o), 0);
    check("t3_drain_cnt", 32'(count_o), 0);

    // Target mismatch flush with concurrent push
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 31'(32'h30 + 4*i), 1'b1, 31'h40);
      step();
    end
    check("t4_count3", 32'(count_o), 3);
    set_push(1'b1, 31'h3c, 1'b1, 31'h40);
    set_res(1'b1, 1'b1, 31'h44);
    step();
    set_push(1'b0, '0, 1'b0, '0);
    set_res(1'b0, 1'b0, '0);
    check("t4_mis",      32'(mispredict_o), 1);
    check("t4_redirect", 32'(redirect_pc_o), 32'h44);
    check("t4_set_pc",   32'(set_pc_o), 32'h30);
    check("t4_count",    32'(count_o), 0);
    check("t4_push_rdy0", 32'(push_ready_o), 0);
    step();
    check("t4_push_rdy1", 32'(push_ready_o), 1);
    check("t4_count_after", 32'(count_o), 0);
    check("t4_res_rdy",  32'(resolve_ready_o), 0);

    // Resolve while empty is ignored
    set_res(1'b1, 1'b1, 31'h55);
    #1;
    check("t5_res_rdy_empty", 32'(resolve_ready_o), 0);
    step();
    set_res(1'b0, 1'b0, '0);
    check("t5_no_fb",  32'(feedback_valid_o), 0);
    check("t5_count",  32'(count_o), 0);

    // Reset mid-flight, with a resolve pending at the same edge
    set_push(1'b1, 31'h50, 1'b0, 31'h60);
    step();
    set_push(1'b1, 31'h54, 1'b0, 31'h60);
    step();
    set_push(1'b0, '0, 1'b0, '0);
    check("t6_count2", 32'(count_o), 2);
    set_res(1'b1, 1'b1, 31'h99);
    rst_n = 1'b0;
    step();
    set_res(1'b0, 1'b0, '0);
    check("t6_rst_count", 32'(count_o), 0);
    check("t6_rst_fb",    32'(feedback_valid_o), 0);
    check("t6_rst_mis",   32'(mispredict_o), 0);
    rst_n = 1'b1;
    step();
    check("t6_push_rdy",  32'(push_ready_o), 1);
    check("t6_res_rdy",   32'(resolve_ready_o), 0);

`ifdef BRU_STATS_EN
    check("t7_stat_br0",  stat_branches_o, 0);
    check("t7_stat_mis0", stat_mispredicts_o, 0);
    for (int i = 0; i < 10; i++) begin
      set_push(1'b1, 31'(32'h400 + 4*i), 1'b1, 31'h40);
      step();
      set_push(1'b0, '0, 1'b0, '0);
      set_res(1'b1, 1'b1, (i == 2 || i == 5 || i == 8) ? 31'h44 : 31'h40);
      step();
      set_res(1'b0, 1'b0, '0);
      step();
    end
    check("t7_stat_br",  stat_branches_o, 10);
    check("t7_stat_mis", stat_mispredicts_o, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
